// File: rtl/fp_normalize_round_pkg.sv
// Shared floating-point field definitions for the adder/subtractor datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_normalize_round_pkg;

    // Single-precision field widths used across the FP datapath.
    localparam int unsigned FP_SIZE_MANTISSA = 23;
    localparam int unsigned FP_SIZE_EXPONENT = 8;

    // Biased exponent value reserved for infinity/NaN at a given exponent width.
    function automatic int unsigned fp_exp_all_ones(input int unsigned size_exponent);
        return (32'd1 << size_exponent) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment on a significand with guard and sticky bits.
// Latency: combinational.
// Backpressure: none; follows whatever stage instantiates it.
module fp_round_rne #(
    parameter int unsigned Width = 24
) (
    input  logic [Width-1:0] sig_i,
    input  logic             guard_i,
    input  logic             sticky_i,
    output logic [Width-1:0] sig_o,
    output logic             carry_o,
    output logic             inexact_o
);

    logic             round_up;
    logic [Width:0]   sum;

    // Ties go to the even significand: only round up on a tie when the LSB is odd.
    assign round_up  = guard_i & (sticky_i | sig_i[0]);
    assign sum       = {1'b0, sig_i} + {{Width{1'b0}}, round_up};
    assign sig_o     = sum[Width-1:0];
    assign carry_o   = sum[Width];
    assign inexact_o = guard_i | sticky_i;

endmodule

// File: rtl/fp_normalize_round.sv
// Normalizes an unpacked FP result and RNE-rounds it into packed {sign, exponent, fraction} plus flags.
// Latency: 2 cycles (stage 1 normalize, stage 2 round/pack), one result per cycle.
// Backpressure: ready_o = ~valid_o | ready_i; a stalled output freezes both stages.
module fp_normalize_round
    import fp_normalize_round_pkg::*;
#(
    parameter int unsigned SizeMantissa = FP_SIZE_MANTISSA,
    parameter int unsigned SizeExponent = FP_SIZE_EXPONENT
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic                                sign_i,
    input  logic [SizeExponent-1:0]             exponent_i,
    input  logic [SizeMantissa+2:0]             mantissa_i,
    input  logic                                sticky_i,
    input  logic [$clog2(SizeMantissa+3)-1:0]   leading_zeros_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [SizeExponent+SizeMantissa:0]  result_o,
    output logic                                overflow_o,
    output logic                                underflow_o,
    output logic                                inexact_o
);

    localparam int unsigned MantW = SizeMantissa + 3;
    // Two spare bits so exponent+carry+round never wraps before the overflow compare.
    localparam int unsigned ExpW  = SizeExponent + 2;
    localparam logic [ExpW-1:0] ExpOne     = ExpW'(1);
    localparam logic [ExpW-1:0] ExpAllOnes = ExpW'(fp_exp_all_ones(SizeExponent));

    // ---------------- Stage 1: normalize ----------------
    logic [ExpW-1:0]  exp_ext;
    logic [ExpW-1:0]  lz_ext;
    logic [ExpW-1:0]  lz_m1;
    logic [ExpW-1:0]  exp_m1;
    logic [ExpW-1:0]  shift_amt;
    logic [MantW-2:0] s1_mant_d;
    logic [MantW-2:0] s1_mant_q;
    logic [ExpW-1:0]  s1_exp_d;
    logic [ExpW-1:0]  s1_exp_q;
    logic             s1_sticky_d;
    logic             s1_sticky_q;
    logic             s1_zero_d;
    logic             s1_zero_q;
    logic             s1_sign_q;
    logic             s1_vld_q;

    // Carry set: shift right one place. Otherwise shift left, but never below exponent 1,
    // so values too small to reach the hidden bit land as subnormals.
    always_comb begin
        exp_ext     = {2'b00, exponent_i};
        lz_ext      = ExpW'(leading_zeros_i);
        lz_m1       = (lz_ext == '0) ? '0 : lz_ext - ExpOne;
        exp_m1      = (exp_ext == '0) ? '0 : exp_ext - ExpOne;
        shift_amt   = '0;
        s1_mant_d   = mantissa_i[MantW-1:1];
        s1_exp_d    = exp_ext + ExpOne;
        s1_sticky_d = sticky_i | mantissa_i[0];
        s1_zero_d   = (mantissa_i == '0);
        if (!mantissa_i[MantW-1]) begin
            shift_amt   = (lz_m1 < exp_m1) ? lz_m1 : exp_m1;
            s1_mant_d   = mantissa_i[MantW-2:0] << shift_amt;
            s1_exp_d    = exp_ext - shift_amt;
            s1_sticky_d = sticky_i;
        end
    end

    // Stage 1 register: advances with the pipeline, data captured only for valid input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_mant_q   <= '0;
            s1_sticky_q <= 1'b0;
            s1_zero_q   <= 1'b0;
        end else if (ready_o) begin
            s1_vld_q <= valid_i;
            if (valid_i) begin
                s1_sign_q   <= sign_i;
                s1_exp_q    <= s1_exp_d;
                s1_mant_q   <= s1_mant_d;
                s1_sticky_q <= s1_sticky_d;
                s1_zero_q   <= s1_zero_d;
            end
        end
    end

    // ---------------- Stage 2: round and pack ----------------
    logic [SizeMantissa:0]              sig;
    logic [SizeMantissa:0]              sig_rnd;
    logic                               rnd_carry;
    logic                               rnd_inexact;
    logic [ExpW-1:0]                    exp_final;
    logic [SizeMantissa-1:0]            frac_final;
    logic [SizeExponent+SizeMantissa:0] result_d;
    logic [SizeExponent+SizeMantissa:0] result_q;
    logic                               ovf_d;
    logic                               unf_d;
    logic                               inx_d;
    logic                               ovf_q;
    logic                               unf_q;
    logic                               inx_q;
    logic                               valid_q;

    // Significand is hidden bit plus fraction; bit 0 of the stage register is the guard.
    assign sig = s1_mant_q[MantW-2:1];

    fp_round_rne #(
        .Width (SizeMantissa + 1)
    ) u_round (
        .sig_i     (sig),
        .guard_i   (s1_mant_q[0]),
        .sticky_i  (s1_sticky_q),
        .sig_o     (sig_rnd),
        .carry_o   (rnd_carry),
        .inexact_o (rnd_inexact)
    );

    // Fold rounding carry into the exponent, encode subnormals, then apply zero/overflow overrides.
    always_comb begin
        exp_final  = s1_exp_q;
        frac_final = sig_rnd[SizeMantissa-1:0];
        if (rnd_carry) begin
            exp_final  = s1_exp_q + ExpOne;
            frac_final = '0;
        end else if (!sig_rnd[SizeMantissa]) begin
            exp_final = '0;
        end
        result_d = {s1_sign_q, exp_final[SizeExponent-1:0], frac_final};
        ovf_d    = 1'b0;
        inx_d    = rnd_inexact;
        // Tiny means the hidden bit was still clear after normalization, before rounding.
        unf_d    = rnd_inexact & ~sig[SizeMantissa];
        if (s1_zero_q) begin
            result_d = {s1_sign_q, {(SizeExponent + SizeMantissa){1'b0}}};
            inx_d    = 1'b0;
            unf_d    = 1'b0;
        end else if (exp_final >= ExpAllOnes) begin
            result_d = {s1_sign_q, ExpAllOnes[SizeExponent-1:0], {SizeMantissa{1'b0}}};
            ovf_d    = 1'b1;
            inx_d    = 1'b1;
            unf_d    = 1'b0;
        end
    end

    // Output register: holds result and flags while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else if (ready_o) begin
            valid_q <= s1_vld_q;
            if (s1_vld_q) begin
                result_q <= result_d;
                ovf_q    <= ovf_d;
                unf_q    <= unf_d;
                inx_q    <= inx_d;
            end
        end
    end

    assign ready_o     = ~valid_q | ready_i;
    assign valid_o     = valid_q;
    assign result_o    = result_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
    assign inexact_o   = inx_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Self-checking bench for fp_normalize_round (single precision).
// Latency: n/a.
// Backpressure: exercised through ready_i stalls and random ready patterns.
module tb_fp_normalize_round;

    localparam int SM  = 23;
    localparam int SE  = 8;
    localparam int MW  = SM + 3;
    localparam int LZW = $clog2(MW);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic            sign_i = 1'b0;
    logic [SE-1:0]   exponent_i = '0;
    logic [MW-1:0]   mantissa_i = '0;
    logic            sticky_i = 1'b0;
    logic [LZW-1:0]  leading_zeros_i = '0;
    logic            valid_o;
    logic            ready_i = 1'b1;
    logic [31:0]     result_o;
    logic            overflow_o;
    logic            underflow_o;
    logic            inexact_o;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        ov;
        logic        un;
        logic        ix;
    } exp_t;

    exp_t exp_q[$];

    fp_normalize_round #(
        .SizeMantissa (SM),
        .SizeExponent (SE)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .sign_i          (sign_i),
        .exponent_i      (exponent_i),
        .mantissa_i      (mantissa_i),
        .sticky_i        (sticky_i),
        .leading_zeros_i (leading_zeros_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .result_o        (result_o),
        .overflow_o      (overflow_o),
        .underflow_o     (underflow_o),
        .inexact_o       (inexact_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int count_lz(input logic [MW-1:0] m);
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (m[i]) found = 1'b1;
            if (!found) n++;
        end
        return n;
    endfunction

    // Reference: value = m * 2^(e - bias - SM - 1); renormalize, then round to nearest even
    // using integer arithmetic on a 24-bit significand.
    function automatic exp_t ref_model(input logic s, input int e_in, input logic [MW-1:0] m_in,
                                       input logic st_in);
        exp_t  r;
        longint m;
        longint q;
        longint q_pre;
        int    e;
        int    sh;
        int    field;
        bit    st;
        bit    g;
        r.res = '0;
        r.ov  = 1'b0;
        r.un  = 1'b0;
        r.ix  = 1'b0;
        m  = longint'(m_in);
        e  = e_in;
        st = st_in;
        if (m == 0) begin
            r.res = {s, 31'd0};
            return r;
        end
        if (m >= 2**25) begin
            st = st | (m % 2 == 1);
            m  = m / 2;
            e  = e + 1;
        end else begin
            sh = count_lz(m_in) - 1;
            if (e - 1 < sh) sh = e - 1;
            m = m << sh;
            e = e - sh;
        end
        g     = (m % 2 == 1);
        q     = m / 2;
        q_pre = q;
        r.ix  = g | st;
        if (g && (st || (q % 2 == 1))) q = q + 1;
        if (q == 2**24) begin
            q = 2**23;
            e = e + 1;
        end
        field = (q >= 2**23) ? e : 0;
        r.un  = r.ix && (q_pre < 2**23);
        if (field >= 255) begin
            r.res = {s, 8'hFF, 23'd0};
            r.ov  = 1'b1;
            r.ix  = 1'b1;
        end else begin
            r.res = {s, 8'(field), 23'(q)};
        end
        return r;
    endfunction

    task automatic set_inputs(input logic s, input logic [SE-1:0] e, input logic [MW-1:0] m,
                              input logic st);
        sign_i          = s;
        exponent_i      = e;
        mantissa_i      = m;
        sticky_i        = st;
        leading_zeros_i = LZW'(count_lz(m));
    endtask

    // Single transfer into an idle pipeline with ready_i high.
    task automatic apply(input logic s, input logic [SE-1:0] e, input logic [MW-1:0] m,
                         input logic st);
        @(posedge clk); #1;
        set_inputs(s, e, m, st);
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic gen_item(output logic s, output logic [SE-1:0] e, output logic [MW-1:0] m,
                            output logic st);
        int            top;
        int            sel;
        logic [MW-1:0] mask;
        s   = 1'($urandom_range(0, 1));
        st  = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 7);
        if (sel == 0)      e = SE'($urandom_range(1, 6));
        else if (sel == 1) e = SE'($urandom_range(250, 254));
        else               e = SE'($urandom_range(1, 254));
        if ($urandom_range(0, 19) == 0) begin
            m = '0;
        end else begin
            top = $urandom_range(0, MW - 1);
            if ($urandom_range(0, 1) == 1) top = $urandom_range(MW - 3, MW - 1);
            mask = '1;
            mask = mask << top;
            m    = MW'($urandom) & ~mask;
            if ($urandom_range(0, 3) == 0) m = m | ~mask;
            m[top] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++;
        if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        checks++;
        if (result_o !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 00000000", result_o); end
        checks++;
        if ({overflow_o, underflow_o, inexact_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000", {overflow_o, underflow_o, inexact_o});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        apply(1'b0, 8'd127, 26'h1000000, 1'b0);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin failures++; $display("FAIL latency_early: got valid_o=%b expected 0", valid_o); end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1) begin failures++; $display("FAIL latency_due: got valid_o=%b expected 1", valid_o); end
        checks++;
        if (result_o !== 32'h3F800000) begin failures++; $display("FAIL latency_result: got %h expected 3f800000", result_o); end
        checks++;
        if ({overflow_o, underflow_o, inexact_o} !== 3'b000) begin
            failures++;
            $display("FAIL latency_flags: got %b expected 000", {overflow_o, underflow_o, inexact_o});
        end
    endtask

    typedef struct packed {
        logic          s;
        logic [SE-1:0] e;
        logic [MW-1:0] m;
        logic          st;
        logic [31:0]   res;
        logic [2:0]    flags;   // {overflow, underflow, inexact}
    } dir_t;

    task automatic test_directed();
        dir_t cases [14];
        cases[0]  = {1'b0, 8'd127, 26'h1000000, 1'b0, 32'h3F800000, 3'b000};
        cases[1]  = {1'b0, 8'd127, 26'h3000000, 1'b0, 32'h40400000, 3'b000};
        cases[2]  = {1'b0, 8'd127, 26'h1000003, 1'b0, 32'h3F800002, 3'b001};
        cases[3]  = {1'b0, 8'd127, 26'h1000001, 1'b0, 32'h3F800000, 3'b001};
        cases[4]  = {1'b0, 8'd254, 26'h3000000, 1'b0, 32'h7F800000, 3'b101};
        cases[5]  = {1'b1, 8'd127, 26'h0000000, 1'b1, 32'h80000000, 3'b000};
        cases[6]  = {1'b0, 8'd1,   26'h0100000, 1'b0, 32'h00080000, 3'b000};
        cases[7]  = {1'b0, 8'd1,   26'h0100000, 1'b1, 32'h00080000, 3'b011};
        cases[8]  = {1'b0, 8'd127, 26'h1FFFFFF, 1'b0, 32'h40000000, 3'b001};
        cases[9]  = {1'b0, 8'd1,   26'h0FFFFFF, 1'b0, 32'h00800000, 3'b011};
        cases[10] = {1'b0, 8'd127, 26'h0100000, 1'b0, 32'h3D800000, 3'b000};
        cases[11] = {1'b1, 8'd100, 26'h3000001, 1'b0, 32'hB2C00000, 3'b001};
        cases[12] = {1'b0, 8'd127, 26'h1000001, 1'b1, 32'h3F800001, 3'b001};
        cases[13] = {1'b0, 8'd254, 26'h1FFFFFF, 1'b0, 32'h7F800000, 3'b101};
        for (int i = 0; i < 14; i++) begin
            apply(cases[i].s, cases[i].e, cases[i].m, cases[i].st);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (valid_o !== 1'b1) begin failures++; $display("FAIL dir%0d_valid: got %b expected 1", i, valid_o); end
            checks++;
            if (result_o !== cases[i].res) begin
                failures++;
                $display("FAIL dir%0d_result: got %h expected %h", i, result_o, cases[i].res);
            end
            checks++;
            if ({overflow_o, underflow_o, inexact_o} !== cases[i].flags) begin
                failures++;
                $display("FAIL dir%0d_flags: got %b expected %b", i,
                         {overflow_o, underflow_o, inexact_o}, cases[i].flags);
            end
        end
    endtask

    task automatic test_stall();
        logic          s;
        logic [SE-1:0] e;
        logic [MW-1:0] m;
        logic          st;
        bit            taken;
        int            wait_cnt;
        int            got;
        int            cyc;
        int            stall_left;
        bit            stalled;
        logic [31:0]   held;
        exp_t          x;
        exp_q.delete();
        got        = 0;
        cyc        = 0;
        stall_left = 0;
        stalled    = 1'b0;
        held       = '0;
        fork
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 4; i++) begin
                    gen_item(s, e, m, st);
                    set_inputs(s, e, m, st);
                    valid_i  = 1'b1;
                    taken    = 1'b0;
                    wait_cnt = 0;
                    while (!taken && wait_cnt < 50) begin
                        @(negedge clk);
                        taken = ready_o;
                        @(posedge clk); #1;
                        wait_cnt++;
                    end
                    checks++;
                    if (!taken) begin failures++; $display("FAIL stall_accept%0d: got timeout expected accept", i); end
                    else exp_q.push_back(ref_model(s, int'(e), m, st));
                end
                valid_i = 1'b0;
            end
            begin
                ready_i = 1'b1;
                while (got < 4 && cyc < 100) begin
                    @(posedge clk); #1;
                    if (!stalled && got >= 1 && valid_o) begin
                        ready_i    = 1'b0;
                        stall_left = 3;
                        stalled    = 1'b1;
                    end else if (stall_left > 0) begin
                        stall_left--;
                        if (stall_left == 0) ready_i = 1'b1;
                    end
                    @(negedge clk);
                    cyc++;
                    if (!ready_i) begin
                        checks++;
                        if (ready_o !== 1'b0) begin failures++; $display("FAIL stall_ready: got %b expected 0", ready_o); end
                        checks++;
                        if (valid_o !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b expected 1", valid_o); end
                        if (stall_left == 3) held = result_o;
                        else begin
                            checks++;
                            if (result_o !== held) begin
                                failures++;
                                $display("FAIL stall_hold: got %h expected %h", result_o, held);
                            end
                        end
                    end else if (valid_o) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL stall_extra: got result %h expected none", result_o);
                        end else begin
                            x = exp_q.pop_front();
                            if (result_o !== x.res || {overflow_o, underflow_o, inexact_o} !== {x.ov, x.un, x.ix}) begin
                                failures++;
                                $display("FAIL stall_item%0d: got %h/%b expected %h/%b", got, result_o,
                                         {overflow_o, underflow_o, inexact_o}, x.res, {x.ov, x.un, x.ix});
                            end
                        end
                        got++;
                    end
                end
            end
        join
        checks++;
        if (got != 4) begin failures++; $display("FAIL stall_count: got %0d expected 4", got); end
        checks++;
        if (!stalled) begin failures++; $display("FAIL stall_applied: got 0 stalls expected 1"); end
        repeat (3) @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stall_drain: got valid_o=%b pending=%0d expected 0/0", valid_o, exp_q.size());
        end
    endtask

    task automatic test_random();
        localparam int N = 300;
        logic          s;
        logic [SE-1:0] e;
        logic [MW-1:0] m;
        logic          st;
        bit            taken;
        int            wait_cnt;
        int            got;
        int            cyc;
        exp_t          x;
        exp_q.delete();
        got = 0;
        cyc = 0;
        fork
            begin
                @(posedge clk); #1;
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        valid_i = 1'b0;
                        @(posedge clk); #1;
                    end
                    gen_item(s, e, m, st);
                    set_inputs(s, e, m, st);
                    valid_i  = 1'b1;
                    taken    = 1'b0;
                    wait_cnt = 0;
                    while (!taken && wait_cnt < 100) begin
                        @(negedge clk);
                        taken = ready_o;
                        @(posedge clk); #1;
                        wait_cnt++;
                    end
                    if (!taken) begin
                        checks++;
                        failures++;
                        $display("FAIL rand_accept%0d: got timeout expected accept", i);
                    end else begin
                        exp_q.push_back(ref_model(s, int'(e), m, st));
                    end
                end
                valid_i = 1'b0;
            end
            begin
                while (got < N && cyc < 20000) begin
                    @(posedge clk); #1;
                    ready_i = ($urandom_range(0, 9) < 7);
                    @(negedge clk);
                    cyc++;
                    if (valid_o && !ready_i) begin
                        checks++;
                        if (ready_o !== 1'b0) begin failures++; $display("FAIL rand_ready: got %b expected 0", ready_o); end
                    end
                    if (valid_o && ready_i) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL rand_extra: got result %h expected none", result_o);
                        end else begin
                            x = exp_q.pop_front();
                            if (result_o !== x.res || {overflow_o, underflow_o, inexact_o} !== {x.ov, x.un, x.ix}) begin
                                failures++;
                                $display("FAIL rand_item%0d: got %h/%b expected %h/%b", got, result_o,
                                         {overflow_o, underflow_o, inexact_o}, x.res, {x.ov, x.un, x.ix});
                            end
                        end
                        got++;
                    end
                end
                ready_i = 1'b1;
            end
        join
        checks++;
        if (got != N) begin failures++; $display("FAIL rand_count: got %0d expected %0d", got, N); end
    endtask

    task automatic test_reset_midflight();
        bit saw_valid;
        exp_q.delete();
        ready_i = 1'b1;
        @(posedge clk); #1;
        set_inputs(1'b0, 8'd130, 26'h1800000, 1'b0);
        valid_i = 1'b1;
        @(posedge clk); #1;
        set_inputs(1'b1, 8'd90, 26'h0400000, 1'b1);
        @(posedge clk); #3;
        valid_i = 1'b0;
        rst_n   = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected 0", valid_o); end
        checks++;
        if (ready_o !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b expected 1", ready_o); end
        checks++;
        if (result_o !== 32'h0 || {overflow_o, underflow_o, inexact_o} !== 3'b000) begin
            failures++;
            $display("FAIL midrst_clear: got %h/%b expected 00000000/000", result_o,
                     {overflow_o, underflow_o, inexact_o});
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        saw_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (valid_o !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin failures++; $display("FAIL midrst_spurious: got valid_o=1 expected 0"); end
        apply(1'b0, 8'd127, 26'h3000000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || result_o !== 32'h40400000) begin
            failures++;
            $display("FAIL midrst_recover: got %b/%h expected 1/40400000", valid_o, result_o);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_stall();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_normalize_round.md
FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

Interface
REQ-001 SHALL have parameter SizeMantissa, default 23, stored fraction width.
REQ-002 SHALL have parameter SizeExponent, default 8, biased exponent width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port valid_i, input, 1, upstream data valid.
REQ-006 SHALL have port ready_o, output, 1, block accepts data this cycle.
REQ-007 SHALL have port sign_i, input, 1, result sign.
REQ-008 SHALL have port exponent_i, input, SizeExponent, effective biased exponent, range 1..2^SizeExponent-2.
REQ-009 SHALL have port mantissa_i, input, SizeMantissa+3, laid out as [SM+2] carry, [SM+1] hidden, [SM:1] fraction, [0] guard.
REQ-010 SHALL have port sticky_i, input, 1, OR of bits already shifted out upstream.
REQ-011 SHALL have port leading_zeros_i, input, clog2(SizeMantissa+3), leading-zero count of mantissa_i from the leading-zero-counter stage.
REQ-012 SHALL have port valid_o, output, 1, result valid.
REQ-013 SHALL have port ready_i, input, 1, downstream accepts result.
REQ-014 SHALL have port result_o, output, 1+SizeExponent+SizeMantissa, packed {sign, exponent, fraction}.
REQ-015 SHALL have ports overflow_o, underflow_o and inexact_o, each output, 1, exception flags qualified by valid_o.

Function
REQ-016 SHALL be a 2-stage pipeline: stage 1 normalizes (shift and exponent adjust); stage 2 rounds and packs.
REQ-017 SHALL produce a result 2 cycles after acceptance when ready_i stays high, sustaining 1 result per cycle.
REQ-018 SHALL accept input when valid_i and ready_o are both high, and SHALL present output while valid_o is high until ready_i is high.
REQ-019 SHALL drive ready_o = ~valid_o | ready_i; both stages advance only when ready_o is high; on a stall, all stage registers and outputs SHALL hold.
REQ-020 SHALL, when mantissa_i[SM+2]=1, shift right by 1, increment the exponent, and OR the old guard into sticky.
REQ-021 SHALL, otherwise, shift left by s = min(leading_zeros_i-1, exponent_i-1) and set the exponent to exponent_i-s.
REQ-022 SHALL encode the exponent field as 0 (subnormal) when the hidden bit is 0 after the shift.
REQ-023 SHALL round to nearest, ties to even: increment the fraction when guard & (sticky | fraction LSB).
REQ-024 SHALL, on rounding carry-out of the hidden bit, increment the exponent and keep the fraction at 0; a subnormal that rounds up into the hidden bit SHALL get exponent field 1.
REQ-025 SHALL, when the final exponent is at least 2^SizeExponent-1, output signed infinity and set overflow_o and inexact_o.
REQ-026 SHALL set inexact_o = guard | sticky after normalization, and underflow_o = inexact_o & (exponent field 0 before rounding).
REQ-027 SHALL, when mantissa_i is all zeros, output {sign_i, 0, 0} with all flags 0, ignoring leading_zeros_i.
REQ-028 SHALL compute the exponent internally at width SizeExponent+2 so that no intermediate value wraps.

Reset
REQ-029 SHALL, while rst_n is low, immediately clear valid_o, the internal stage-valid bit, result_o and all flags; ready_o then reads 1.
REQ-030 SHALL discard in-flight data on reset mid-operation and emit no spurious valid_o after release.

Structure
REQ-031 SHALL take field widths and the exponent all-ones constant from the shared FP package used by the adder/subtractor datapath.
REQ-032 SHALL use a single sub-module, fp_round_rne, for the rounding increment, carry-out and inexact logic in stage 2; the normalize shifter stays inline.

Verification (SM=23, SE=8)
REQ-033 SHALL check: mantissa_i={0,1,23'h0,0}, exp 127, lz 1 -> result 0x3F800000, no flags, valid_o exactly 2 cycles later.
REQ-034 SHALL check: mantissa_i={1,1,23'h0,0}, exp 127, lz 0 -> result 0x40400000.
REQ-035 SHALL check: fraction LSB 1, guard 1, sticky 0, exp 127 -> fraction rounds up to even and inexact_o=1; the same case with LSB 0 -> no increment.
REQ-036 SHALL check: carry set, exp 254 -> result 0x7F800000, overflow_o=1, inexact_o=1.
REQ-037 SHALL check: mantissa 0 with sign 1 -> result 0x80000000; exp 1 with lz 5 -> subnormal, exponent field 0.
REQ-038 SHALL check: ready_i low for 3 cycles during a stream of 4 inputs -> result_o held stable, ready_o low, no loss or duplication, order preserved.
